// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control stage: opcode values, ALU Oper encodings
// and the decoded control bundle carried through the skid buffer.
package alu_ctrl_pkg;

    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned OPER_WIDTH  = 4;

    localparam logic [OPER_WIDTH-1:0] OPER_RLL = 4'd0;
    localparam logic [OPER_WIDTH-1:0] OPER_SLL = 4'd1;
    localparam logic [OPER_WIDTH-1:0] OPER_RRL = 4'd2;
    localparam logic [OPER_WIDTH-1:0] OPER_SRL = 4'd3;
    localparam logic [OPER_WIDTH-1:0] OPER_ADD = 4'd4;
    localparam logic [OPER_WIDTH-1:0] OPER_AND = 4'd5;
    localparam logic [OPER_WIDTH-1:0] OPER_OR  = 4'd6;
    localparam logic [OPER_WIDTH-1:0] OPER_XOR = 4'd7;
    localparam logic [OPER_WIDTH-1:0] OPER_BTR = 4'd8;
    localparam logic [OPER_WIDTH-1:0] OPER_RTB = 4'd9;
    localparam logic [OPER_WIDTH-1:0] OPER_RTA = 4'd10;

    localparam logic [4:0] OPC_ST    = 5'b10000;
    localparam logic [4:0] OPC_LD    = 5'b10001;
    localparam logic [4:0] OPC_STU   = 5'b10011;
    localparam logic [4:0] OPC_ADDI  = 5'b01000;
    localparam logic [4:0] OPC_SUBI  = 5'b01001;
    localparam logic [4:0] OPC_XORI  = 5'b01010;
    localparam logic [4:0] OPC_ANDNI = 5'b01011;
    localparam logic [4:0] OPC_ROLI  = 5'b10100;
    localparam logic [4:0] OPC_SLLI  = 5'b10101;
    localparam logic [4:0] OPC_RORI  = 5'b10110;
    localparam logic [4:0] OPC_SRLI  = 5'b10111;
    localparam logic [4:0] OPC_LBI   = 5'b11000;
    localparam logic [4:0] OPC_BTR   = 5'b11001;
    localparam logic [4:0] OPC_SHIFT = 5'b11010;
    localparam logic [4:0] OPC_RTYPE = 5'b11011;
    localparam logic [4:0] OPC_SEQ   = 5'b11100;
    localparam logic [4:0] OPC_SLT   = 5'b11101;
    localparam logic [4:0] OPC_SLE   = 5'b11110;
    localparam logic [4:0] OPC_SCO   = 5'b11111;

    typedef struct packed {
        logic [OPER_WIDTH-1:0]  oper;
        logic                   inva;
        logic                   invb;
        logic                   cin;
        logic                   sign;
        logic                   use_imm;
        logic [INSTR_WIDTH-1:0] imm;
        logic                   illegal;
    } ctrl_t;

    // Shift/rotate selectors (funct or low opcode bits) map 1:1 onto RLL..SRL.
    function automatic logic [OPER_WIDTH-1:0] shift_oper(input logic [1:0] sel);
        return {2'b00, sel};
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational instruction decoder producing the ALU control fields and the
// extended immediate for one 16-bit instruction.
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic [OPER_WIDTH-1:0]  alu_oper,
    output logic                   alu_inva,
    output logic                   alu_invb,
    output logic                   alu_cin,
    output logic                   alu_sign,
    output logic                   use_imm,
    output logic [INSTR_WIDTH-1:0] imm,
    output logic                   illegal
);

    logic [4:0]             opcode;
    logic [1:0]             funct;
    logic [INSTR_WIDTH-1:0] imm5_sext;
    logic [INSTR_WIDTH-1:0] imm5_zext;
    logic [INSTR_WIDTH-1:0] imm8_sext;
    logic                   unused_bits;

    assign opcode      = instr[15:11];
    assign funct       = instr[1:0];
    assign imm5_sext   = {{11{instr[4]}}, instr[4:0]};
    assign imm5_zext   = {11'd0, instr[4:0]};
    assign imm8_sext   = {{8{instr[7]}}, instr[7:0]};
    assign unused_bits = ^instr[10:8];

    always_comb begin
        alu_oper = OPER_RTA;
        alu_inva = 1'b0;
        alu_invb = 1'b0;
        alu_cin  = 1'b0;
        alu_sign = 1'b0;
        use_imm  = 1'b0;
        imm      = '0;
        illegal  = 1'b0;
        unique case (opcode)
            OPC_RTYPE: begin
                unique case (funct)
                    2'b00: alu_oper = OPER_ADD;
                    2'b01: begin
                        alu_oper = OPER_ADD;
                        alu_inva = 1'b1;
                        alu_cin  = 1'b1;
                    end
                    2'b10: alu_oper = OPER_XOR;
                    default: begin
                        alu_oper = OPER_AND;
                        alu_invb = 1'b1;
                    end
                endcase
            end
            OPC_SHIFT: alu_oper = shift_oper(funct);
            OPC_ADDI, OPC_ST, OPC_LD, OPC_STU: begin
                alu_oper = OPER_ADD;
                use_imm  = 1'b1;
                imm      = imm5_sext;
            end
            OPC_SUBI: begin
                alu_oper = OPER_ADD;
                alu_inva = 1'b1;
                alu_cin  = 1'b1;
                use_imm  = 1'b1;
                imm      = imm5_sext;
            end
            OPC_XORI: begin
                alu_oper = OPER_XOR;
                use_imm  = 1'b1;
                imm      = imm5_zext;
            end
            OPC_ANDNI: begin
                alu_oper = OPER_AND;
                alu_invb = 1'b1;
                use_imm  = 1'b1;
                imm      = imm5_zext;
            end
            OPC_ROLI, OPC_SLLI, OPC_RORI, OPC_SRLI: begin
                alu_oper = shift_oper(opcode[1:0]);
                use_imm  = 1'b1;
                imm      = imm5_zext;
            end
            OPC_BTR: alu_oper = OPER_BTR;
            OPC_SEQ, OPC_SLT, OPC_SLE: begin
                alu_oper = OPER_ADD;
                alu_invb = 1'b1;
                alu_cin  = 1'b1;
                alu_sign = 1'b1;
            end
            OPC_SCO: alu_oper = OPER_ADD;
            OPC_LBI: begin
                alu_oper = OPER_RTB;
                use_imm  = 1'b1;
                imm      = imm8_sext;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Decode-to-execute control stage: decodes fetched instructions and buffers the
// ALU controls in a two-entry skid buffer between two valid/ready handshakes.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPER_WIDTH-1:0]  alu_oper,
    output logic                   alu_inva,
    output logic                   alu_invb,
    output logic                   alu_cin,
    output logic                   alu_sign,
    output logic                   use_imm,
    output logic [INSTR_WIDTH-1:0] imm,
    output logic                   illegal
);

    ctrl_t dec_ctrl;
    ctrl_t main_d, main_q;
    ctrl_t skid_d, skid_q;
    logic  out_valid_d, out_valid_q;
    logic  skid_valid_d, skid_valid_q;
    logic  in_acc, out_acc, main_load;

    alu_ctrl_dec u_dec (
        .instr    (instr),
        .alu_oper (dec_ctrl.oper),
        .alu_inva (dec_ctrl.inva),
        .alu_invb (dec_ctrl.invb),
        .alu_cin  (dec_ctrl.cin),
        .alu_sign (dec_ctrl.sign),
        .use_imm  (dec_ctrl.use_imm),
        .imm      (dec_ctrl.imm),
        .illegal  (dec_ctrl.illegal)
    );

    // in_ready depends only on skid state, so out_ready never reaches it combinationally.
    assign in_ready  = !skid_valid_q;
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid_q && out_ready;
    assign main_load = !out_valid_q || out_acc;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_load) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_acc) begin
                main_d      = dec_ctrl;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_acc) begin
            skid_d       = dec_ctrl;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_oper  = main_q.oper;
    assign alu_inva  = main_q.inva;
    assign alu_invb  = main_q.invb;
    assign alu_cin   = main_q.cin;
    assign alu_sign  = main_q.sign;
    assign use_imm   = main_q.use_imm;
    assign imm       = main_q.imm;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: directed cases plus random traffic checked against a
// queue-based model of the buffered stream and a rule-table decode model.
module tb_alu_ctrl_stage;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] instr, imm;
    logic [3:0]  alu_oper;
    logic        alu_inva, alu_invb, alu_cin, alu_sign, use_imm, illegal;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alu_ctrl_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_oper  (alu_oper),
        .alu_inva  (alu_inva),
        .alu_invb  (alu_invb),
        .alu_cin   (alu_cin),
        .alu_sign  (alu_sign),
        .use_imm   (use_imm),
        .imm       (imm),
        .illegal   (illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [3:0] op, input logic ia, input logic ib,
                                         input logic ci, input logic sg, input logic ui,
                                         input logic [15:0] im, input logic il);
        return {6'd0, op, ia, ib, ci, sg, ui, im, il};
    endfunction

    // Decode straight from the instruction-set rules.
    function automatic logic [31:0] ref_dec(input logic [15:0] i);
        logic [3:0]  shifts [4];
        logic [4:0]  op;
        logic [15:0] s5, z5, s8;
        int          f;
        shifts = '{OPER_RLL, OPER_SLL, OPER_RRL, OPER_SRL};
        op = i[15:11];
        f  = int'(i[1:0]);
        s5 = 16'(signed'(i[4:0]));
        z5 = 16'(i[4:0]);
        s8 = 16'(signed'(i[7:0]));
        if (op == 5'b11011) begin
            if (f == 0) return pack(OPER_ADD, 0, 0, 0, 0, 0, 16'd0, 0);
            if (f == 1) return pack(OPER_ADD, 1, 0, 1, 0, 0, 16'd0, 0);
            if (f == 2) return pack(OPER_XOR, 0, 0, 0, 0, 0, 16'd0, 0);
            return pack(OPER_AND, 0, 1, 0, 0, 0, 16'd0, 0);
        end
        if (op == 5'b11010) return pack(shifts[f], 0, 0, 0, 0, 0, 16'd0, 0);
        if (op == 5'b01000 || op == 5'b10000 || op == 5'b10001 || op == 5'b10011)
            return pack(OPER_ADD, 0, 0, 0, 0, 1, s5, 0);
        if (op == 5'b01001) return pack(OPER_ADD, 1, 0, 1, 0, 1, s5, 0);
        if (op == 5'b01010) return pack(OPER_XOR, 0, 0, 0, 0, 1, z5, 0);
        if (op == 5'b01011) return pack(OPER_AND, 0, 1, 0, 0, 1, z5, 0);
        if (op >= 5'b10100 && op <= 5'b10111)
            return pack(shifts[int'(op) - 20], 0, 0, 0, 0, 1, z5, 0);
        if (op == 5'b11001) return pack(OPER_BTR, 0, 0, 0, 0, 0, 16'd0, 0);
        if (op >= 5'b11100 && op <= 5'b11110) return pack(OPER_ADD, 0, 1, 1, 1, 0, 16'd0, 0);
        if (op == 5'b11111) return pack(OPER_ADD, 0, 0, 0, 0, 0, 16'd0, 0);
        if (op == 5'b11000) return pack(OPER_RTB, 0, 0, 0, 0, 1, s8, 0);
        return pack(OPER_RTA, 0, 0, 0, 0, 0, 16'd0, 1);
    endfunction

    function automatic logic [31:0] dut_payload();
        return pack(alu_oper, alu_inva, alu_invb, alu_cin, alu_sign, use_imm, imm, illegal);
    endfunction

    // One clock: predict handshakes from the model, advance it, then compare.
    task automatic cycle();
        bit acc_out, acc_in;
        acc_out = exp_q.size() > 0 && out_ready;
        acc_in  = !flush && in_valid && exp_q.size() < 2;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (acc_out) void'(exp_q.pop_front());
            if (acc_in) exp_q.push_back(ref_dec(instr));
        end
        #1;
        check_eq("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check_eq("payload", dut_payload(), exp_q[0]);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; instr = '0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_payload", dut_payload(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        in_valid = 1'b1; out_ready = 1'b1; instr = 16'hD801;
        cycle();
        check_eq("d801_oper", 32'(alu_oper), 32'(OPER_ADD));
        check_eq("d801_inva_cin", 32'({alu_inva, alu_cin, alu_invb, use_imm, illegal}),
                 32'b11000);

        instr = 16'h401F; cycle();
        check_eq("addi_imm", 32'(imm), 32'hFFFF);
        check_eq("addi_use_imm", 32'(use_imm), 32'd1);
        instr = 16'h501F; cycle();
        check_eq("xori_imm", 32'(imm), 32'h001F);
        check_eq("xori_oper", 32'(alu_oper), 32'(OPER_XOR));
        instr = 16'hC080; cycle();
        check_eq("lbi_imm", 32'(imm), 32'hFF80);
        check_eq("lbi_oper", 32'(alu_oper), 32'(OPER_RTB));
        in_valid = 1'b0; cycle();

        // Backpressure: two entries fill the buffer, third waits upstream.
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 16'hD800; cycle();
        instr = 16'hD802; cycle();
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        instr = 16'hD803; cycle();
        check_eq("bp_hold_oper", 32'(alu_oper), 32'(OPER_ADD));
        out_ready = 1'b1; cycle();
        check_eq("bp_second_oper", 32'(alu_oper), 32'(OPER_XOR));
        cycle();
        check_eq("bp_third_invb", 32'({alu_oper, alu_invb}), 32'({OPER_AND, 1'b1}));
        in_valid = 1'b0; cycle();
        check_eq("bp_drained", 32'(out_valid), 32'd0);

        out_ready = 1'b0; in_valid = 1'b1;
        instr = 16'hD800; cycle();
        instr = 16'hD802; cycle();
        flush = 1'b1; instr = 16'hD801; cycle();
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cycle();

        in_valid = 1'b1; instr = 16'h7800; cycle();
        check_eq("illegal_flag", 32'({alu_oper, alu_inva, alu_invb, alu_cin, alu_sign, illegal}),
                 32'({OPER_RTA, 5'b00001}));
        instr = 16'hE800; cycle();
        check_eq("slt_ctrl", 32'({alu_oper, alu_invb, alu_cin, alu_sign}),
                 32'({OPER_ADD, 3'b111}));

        out_ready = 1'b0; instr = 16'h401F; cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_payload", dut_payload(), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 500; n++) begin
            instr     = 16'($urandom);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 24) == 0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
Decode-to-execute control stage that drives the control inputs of the 16-bit ALU: Oper, invA, invB, Cin and sign, plus the immediate operand select.
- Accepts 16-bit instructions from fetch over a valid/ready handshake.
- Decodes each one into ALU control fields and holds them in a two-entry skid buffer.
- Presents the fields to the execute stage over a second valid/ready handshake.
- Full throughput with no combinational path from out_ready to in_ready.

Parameters:
INSTR_WIDTH, 16, instruction width; fixed at 16 for this ISA.
OPER_WIDTH, 4, width of the ALU Oper field.

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  fetch presents instr
in_ready  output  1  stage can accept; registered, equals !skid_valid
instr  input  16  instruction word
flush  input  1  synchronous kill of all held entries
out_valid  output  1  decoded entry available
out_ready  input  1  execute accepts entry
alu_oper  output  4  ALU Oper encoding (RLL/SLL/RRL/SRL/ADD/AND/OR/XOR/BTR/RTB/RTA)
alu_inva  output  1  invert A
alu_invb  output  1  invert B
alu_cin  output  1  carry in
alu_sign  output  1  signed overflow mode
use_imm  output  1  B operand is imm rather than register
imm  output  16  extended immediate
illegal  output  1  opcode not in decode table

Behaviour:
Reset (rst_n=0, asynchronous):
- out_valid=0, in_ready=1, all payload outputs 0.
- Internal skid_valid=0.

Decode is combinational on instr; opcode is instr[15:11], funct is instr[1:0].
- 11011 (R-type):
  - funct 00: ADD
  - funct 01: ADD, invA=1, Cin=1 (Rt-Rs)
  - funct 10: XOR
  - funct 11: AND, invB=1 (ANDN)
- 11010: funct 00/01/10/11 map to RLL/SLL/RRL/SRL.
- 01000 ADDI: ADD.
- 01001 SUBI: ADD, invA=1, Cin=1.
- 01010 XORI: XOR.
- 01011 ANDNI: AND, invB=1.
- 10100/10101/10110/10111: RLL/SLL/RRL/SRL with immediate.
- 10000/10001/10011 (ST/LD/STU): ADD with immediate.
- 11001 BTR: Oper BTR.
- 11100/11101/11110 (SEQ/SLT/SLE): ADD, invB=1, Cin=1, sign=1.
- 11111 SCO: ADD, sign=0.
- 11000 LBI: RTB with immediate.
- Any other opcode: Oper=RTA, all controls 0, use_imm=0, illegal=1.

Immediate rules:
- imm5 = instr[4:0].
- Sign-extended for ADDI/SUBI/ST/LD/STU.
- Zero-extended for XORI/ANDNI and the shift/rotate immediates.
- LBI: sign-extended instr[7:0].
- use_imm=1 exactly for the I-format and LBI opcodes; otherwise imm=0.

Skid buffer, two entries (main drives outputs, skid holds overflow):
- Input accept when in_valid && in_ready; output accept when out_valid && out_ready.
- Main loads when !out_valid or output accept. Source is skid if skid_valid, else the decoded input if input accept.
- Skid loads decoded input when input accept and main neither empty nor draining.
- Skid clears when main loads from it.
- Simultaneous input accept and output accept with skid empty: main takes the new entry, out_valid stays 1.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (one cycle).
- Throughput: one per cycle when out_ready=1.
- Ordering preserved strictly.

Flush:
- Next edge clears out_valid and skid_valid.
- The same-cycle input accept is discarded.
- Flush has priority over every load.
- Payload registers are not cleared.
- in_ready=1 the cycle after flush.

Other rules:
- Payload outputs are stable while out_valid && !out_ready.
- Reset asserted mid-operation drops all entries immediately.

Decomposition:
- Shared constants file: 5-bit opcode values and the Oper encodings, taken from the existing shared ALU opcode include; no new Oper codes.
- One sub-module: alu_ctrl_dec, pure combinational, instr mapped to {alu_oper, alu_inva, alu_invb, alu_cin, alu_sign, use_imm, imm, illegal}.
- alu_ctrl_stage holds only the handshake and the two registers.

Test Plan:
- Reset release, then instr 16'hD801 with out_ready=1 -> next cycle out_valid=1, oper ADD, inva=1, cin=1, invb=0, use_imm=0, illegal=0.
- instr 16'h401F (ADDI -1) -> imm=16'hFFFF, use_imm=1, oper ADD. Then 16'h501F (XORI) -> imm=16'h001F, oper XOR. Then 16'hC080 (LBI) -> imm=16'hFF80, oper RTB.
- out_ready=0; send 16'hD800, 16'hD802, 16'hD803 back to back:
  - in_ready=0 after the second accept; third instruction held upstream.
  - Raise out_ready -> outputs ADD, XOR, AND+invb in order, one per cycle, none lost or duplicated.
- Buffer holding two entries, flush=1 with in_valid=1 for one cycle -> out_valid=0 and in_ready=1 next cycle; the flushed and incoming instructions never appear.
- instr 16'h7800 (opcode 01111) -> illegal=1, oper RTA, all controls 0. instr 16'hE800 (SLT) -> oper ADD, invb=1, cin=1, sign=1.
- rst_n pulsed low asynchronously while out_valid=1 and out_ready=0 -> out_valid and payload 0 immediately, before the next clk edge; in_ready=1.
